riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu.sv | 173 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding RV32I load/store unit.
// Takes one core request at a time, checks it for legality, issues a
// word-aligned memory access and returns a one-cycle completion pulse.
// Store data is replicated across byte lanes. Load data is extracted from
// its lane and then sign- or zero-extended.
module riscv_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_exception
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_addr;
  logic [2:0]      r_funct3;
  logic            r_store;
  logic [XLEN-1:0] r_wdata;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;
  logic            r_exc;
  logic [CW-1:0]   r_cnt;
  logic            w_illegal;
  logic            w_accept;
  logic            w_cnt_last;

  // Unknown width codes and misaligned halfword/word accesses never reach memory.
  function automatic logic f_illegal(input logic store, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic bad_code;
    logic bad_align;
    bad_code  = store ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    bad_align = ((f3[1:0] == 2'd1) && off[0]) || ((f3[1:0] == 2'd2) && (off != 2'd0));
    return bad_code || bad_align;
  endfunction

  // Byte-lane strobes for a store of the given width at the given offset.
  function automatic logic [3:0] f_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across all lanes, so the strobes alone pick the bytes.
  function automatic logic [XLEN-1:0] f_wdata(input logic [2:0] f3, input logic [XLEN-1:0] wd);
    case (f3[1:0])
      2'd0:    return {(XLEN/8){wd[7:0]}};
      2'd1:    return {(XLEN/16){wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Pick the addressed lane out of the read word and extend it to XLEN.
  function automatic logic [XLEN-1:0] f_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [XLEN-1:0] rd);
    logic [XLEN-1:0] sh_b;
    logic [XLEN-1:0] sh_h;
    logic [7:0]      b;
    logic [15:0]     h;
    sh_b = rd >> {off, 3'b000};
    sh_h = rd >> {off[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (f3)
      3'd0:    return {{(XLEN-8){b[7]}}, b};
      3'd4:    return {{(XLEN-8){1'b0}}, b};
      3'd1:    return {{(XLEN-16){h[15]}}, h};
      3'd5:    return {{(XLEN-16){1'b0}}, h};
      default: return rd;
    endcase
  endfunction

  assign w_illegal  = f_illegal(req_store, req_funct3, req_addr[1:0]);
  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. A load leaves WAIT on its data or when it times out.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_illegal ? S_RESP : S_REQ;
      S_REQ:  if (mem_ready) w_next = r_store ? S_RESP : S_WAIT;
      S_WAIT: if (mem_rvalid || w_cnt_last) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latches, load data capture and the WAIT timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_store  <= 1'b0;
      r_wdata  <= '0;
      r_rd     <= '0;
      r_data   <= '0;
      r_exc    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_funct3 <= req_funct3;
      r_store  <= req_store;
      r_wdata  <= req_wdata;
      r_rd     <= req_rd;
      r_data   <= '0;
      r_exc    <= w_illegal;
      r_cnt    <= '0;
    end else if (r_state == S_WAIT) begin
      if (mem_rvalid)      r_data <= f_extract(r_funct3, r_addr[1:0], mem_rdata);
      else if (w_cnt_last) r_exc  <= 1'b1;
      else                 r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Output decode. Memory strobes are live only in REQ; response fields only in RESP.
  always_comb begin
    req_ready      = (r_state == S_IDLE);
    mem_valid      = (r_state == S_REQ);
    mem_we         = (r_state == S_REQ) && r_store;
    mem_addr       = '0;
    mem_wstrb      = 4'b0000;
    mem_wdata      = '0;
    resp_valid     = (r_state == S_RESP);
    resp_exception = (r_state == S_RESP) && r_exc;
    resp_rd        = '0;
    resp_data      = '0;
    if (r_state == S_REQ) begin
      mem_addr = {r_addr[XLEN-1:2], 2'b00};
      if (r_store) begin
        mem_wstrb = f_wstrb(r_funct3, r_addr[1:0]);
        mem_wdata = f_wdata(r_funct3, r_wdata);
      end
    end
    if ((r_state == S_RESP) && !r_store && !r_exc) begin
      resp_rd   = r_rd;
      resp_data = r_data;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: scoreboard bench for riscv_lsu. Each request pushes its
// expected response. A negedge monitor pops that response and compares it
// when resp_valid fires.
module tb_riscv_lsu;

  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_store;
  logic [2:0]      req_funct3;
  logic [31:0]     req_addr, req_wdata;
  logic [4:0]      req_rd;
  logic            mem_valid, mem_ready, mem_we;
  logic [31:0]     mem_addr, mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            resp_valid, resp_exception;
  logic [4:0]      resp_rd;
  logic [31:0]     resp_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  riscv_lsu #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_exception(resp_exception)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: each completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got rd=%0d data=%h exc=%b, required no response",
                 resp_rd, resp_data, resp_exception);
      end else begin
        mon_e = sb_q.pop_front();
        if (resp_rd !== mon_e.rd || resp_data !== mon_e.data || resp_exception !== mon_e.exc) begin
          errors++;
          $display("FAIL resp_match: got rd=%0d data=%h exc=%b, required rd=%0d data=%h exc=%b",
                   resp_rd, resp_data, resp_exception, mon_e.rd, mon_e.data, mon_e.exc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'd0;
  endtask

  // Present one request in IDLE and let it be accepted on the next edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
    tick();
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, required 1", req_ready);
    end
    checks++;
    if ({mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_mem: got valid=%b we=%b strb=%b addr=%h wdata=%h, required all 0",
                         mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata);
    end
    checks++;
    if ({resp_valid, resp_exception, resp_rd, resp_data} !== '0) begin
      errors++; $display("FAIL reset_resp: got valid=%b exc=%b rd=%0d data=%h, required all 0",
                         resp_valid, resp_exception, resp_rd, resp_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_sw();
    mem_ready = 1'b1;
    sb_q.push_back('{rd: 5'd0, data: 32'h0, exc: 1'b0});
    issue(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd7);
    checks++;
    if ({mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata} !== {2'b11, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
      errors++; $display("FAIL sw_mem: got v=%b we=%b addr=%h strb=%b wdata=%h, required 1 1 00000100 1111 deadbeef",
                         mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL sw_latency: resp_valid got %b, required 1 two cycles after accept", resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL sw_pulse: got resp_valid=%b req_ready=%b, required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3_t [4] = '{3'd0, 3'd0, 3'd1, 3'd1};
    logic [31:0] ad_t [4] = '{32'h103, 32'h101, 32'h102, 32'h100};
    logic [31:0] wd_t [4] = '{32'h000000A5, 32'h12345678, 32'h0000BEEF, 32'hCAFE1234};
    logic [3:0]  st_t [4] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011};
    logic [31:0] mw_t [4] = '{32'hA5A5A5A5, 32'h78787878, 32'hBEEFBEEF, 32'h12341234};
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{rd: 5'd0, data: 32'h0, exc: 1'b0});
      issue(1'b1, f3_t[i], ad_t[i], wd_t[i], 5'd3);
      checks++;
      if (mem_wstrb !== st_t[i] || mem_wdata !== mw_t[i] || mem_addr !== 32'h100) begin
        errors++; $display("FAIL store_lane%0d: got strb=%b wdata=%h addr=%h, required %b %h 00000100",
                           i, mem_wstrb, mem_wdata, mem_addr, st_t[i], mw_t[i]);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3_t [8] = '{3'd0, 3'd4, 3'd1, 3'd1, 3'd5, 3'd2, 3'd0, 3'd4};
    logic [31:0] ad_t [8] = '{32'h201, 32'h201, 32'h202, 32'h200, 32'h200, 32'h204, 32'h203, 32'h200};
    logic [31:0] ex_t [8] = '{32'hFFFFFF80, 32'h00000080, 32'h00001234, 32'hFFFF8000,
                              32'h00008000, 32'h12348000, 32'h00000012, 32'h00000000};
    logic [31:0] aligned;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      aligned = ad_t[i] & 32'hFFFF_FFFC;
      sb_q.push_back('{rd: 5'(i + 1), data: ex_t[i], exc: 1'b0});
      issue(1'b0, f3_t[i], ad_t[i], 32'hFFFFFFFF, 5'(i + 1));
      checks++;
      if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'b0000 || mem_addr !== aligned) begin
        errors++; $display("FAIL load_req%0d: got v=%b we=%b strb=%b addr=%h, required 1 0 0000 %h",
                           i, mem_valid, mem_we, mem_wstrb, mem_addr, aligned);
      end
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12348000;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if (resp_valid !== 1'b1) begin
        errors++; $display("FAIL load_latency%0d: resp_valid got %b, required 1 three cycles after accept",
                           i, resp_valid);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic        st_t [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3_t [9] = '{3'd2, 3'd3, 3'd3, 3'd6, 3'd7, 3'd1, 3'd1, 3'd2, 3'd5};
    logic [31:0] ad_t [9] = '{32'h106, 32'h100, 32'h100, 32'h100, 32'h100,
                              32'h101, 32'h103, 32'h102, 32'h201};
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back('{rd: 5'd0, data: 32'h0, exc: 1'b1});
      issue(st_t[i], f3_t[i], ad_t[i], 32'h55AA55AA, 5'd9);
      checks++;
      if (resp_valid !== 1'b1 || resp_exception !== 1'b1 || mem_valid !== 1'b0) begin
        errors++; $display("FAIL illegal%0d: got resp_valid=%b exc=%b mem_valid=%b, required 1 1 0",
                           i, resp_valid, resp_exception, mem_valid);
      end
      tick();
      checks++;
      if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL illegal_after%0d: got mem_valid=%b resp_valid=%b req_ready=%b, required 0 0 1",
                           i, mem_valid, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_timeout();
    int held;
    int n;
    held = 0;
    n    = 0;
    mem_ready = 1'b0;
    sb_q.push_back('{rd: 5'd0, data: 32'h0, exc: 1'b1});
    issue(1'b0, 3'd2, 32'h300, 32'h0, 5'd3);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem_ready = 1'b1;
      if (mem_valid === 1'b1 && mem_addr === 32'h300) held++;
      tick();
    end
    checks++;
    if (held != 6) begin
      errors++; $display("FAIL timeout_hold: mem_valid stable cycles got %0d, required 6", held);
    end
    while (resp_valid !== 1'b1 && n < TO + 8) begin
      tick();
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++; $display("FAIL timeout_wait: WAIT cycles before response got %0d, required %0d", n, TO);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b1;
    issue(1'b0, 3'd2, 32'h400, 32'h0, 5'd4);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async: got req_ready=%b mem_valid=%b, required 1 0", req_ready, mem_valid);
    end
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    tick();
    mem_rvalid = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_late_rvalid: got resp_valid=%b req_ready=%b, required 0 1",
                         resp_valid, req_ready);
    end
    sb_q.push_back('{rd: 5'd4, data: 32'hA5A55A5A, exc: 1'b0});
    issue(1'b0, 3'd2, 32'h404, 32'h0, 5'd4);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A55A5A;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL rst_recover: resp_valid got %b, required 1", resp_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    sb_q.push_back('{rd: 5'd0, data: 32'h0, exc: 1'b0});
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h500;
    req_wdata  = 32'h01020304;
    req_rd     = 5'd1;
    tick();
    req_store  = 1'b0;
    req_addr   = 32'h504;
    req_rd     = 5'd2;
    checks++;
    if (req_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h500) begin
      errors++; $display("FAIL b2b_store: got ready=%b we=%b addr=%h, required 0 1 00000500",
                         req_ready, mem_we, mem_addr);
    end
    tick();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_busy: req_ready got %b in RESP, required 0", req_ready);
    end
    tick();
    sb_q.push_back('{rd: 5'd2, data: 32'h0BADF00D, exc: 1'b0});
    tick();
    drive_idle();
    checks++;
    if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h504) begin
      errors++; $display("FAIL b2b_load: got v=%b we=%b addr=%h, required 1 0 00000504",
                         mem_valid, mem_we, mem_addr);
    end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    tick();
    mem_rvalid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_store_sw();
    test_store_lanes();
    test_load_extract();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: pending responses got %0d, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
